corr_multi_detector: RTL

Parametrised, multi-channel successor to the single-channel correlation thresholder. It accepts time-multiplexed correlation samples tagged with a channel index and runs a per-channel IIR low-pass filter. Each channel has its own hysteresis detector with a minimum-on hold, and its own runtime-adjustable high/low thresholds. It sits between the correlator bank and the note/game logic, in the correlator clock domain. Display and CDC stay outside this block.

---
 rtl/corr_multi_detector_pkg.sv | 26 ++
 rtl/corr_multi_detector_if.sv | 15 +
 rtl/corr_multi_detector_hyst.sv | 115 +++++++++++
 rtl/corr_multi_detector.sv | 112 +++++++++++
 4 files changed

// File: rtl/corr_multi_detector_pkg.sv
// Shared types and width helpers for the multi-channel correlation detector.
package corr_multi_detector_pkg;

  // Per-channel detector state: idle, active inside the minimum-on hold,
  // and active with the hold satisfied (release allowed).
  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_HOLD  = 2'd1,
    CH_ARMED = 2'd2
  } ch_state_e;

  // Index width that never collapses to zero bits, even for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Largest unsigned value representable in w bits.
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Default configuration: 4 channels, 10-bit datapath.
  localparam int CH_W    = clog2_min1(4);
  localparam int SAT_MAX = sat_max(10);

endpackage

// File: rtl/corr_multi_detector_if.sv
// Tagged correlation sample stream from the correlator bank.
// Handshake: valid-only stream, no backpressure. A sample is consumed on every
// rising clk edge where correlation_valid is 1; correlation and correlation_ch
// are only meaningful in that cycle. The consumer must accept one per cycle.
interface corr_multi_detector_if #(
  parameter int WIDTH = 10,
  parameter int CH_W  = 2
);
  logic [WIDTH-1:0] correlation;
  logic [CH_W-1:0]  correlation_ch;
  logic             correlation_valid;

  modport master (output correlation, output correlation_ch, output correlation_valid);
  modport slave  (input  correlation, input  correlation_ch, input  correlation_valid);
endinterface

// File: rtl/corr_multi_detector_hyst.sv
// One channel's hysteresis detector with minimum-on hold and its own
// runtime-adjustable high/low thresholds.
module corr_hyst_channel
  import corr_multi_detector_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int THRESH_HIGH = 450,
  parameter int THRESH_LOW  = 250,
  parameter int THRESH_STEP = 4,
  parameter int MIN_ON      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             eval,
  input  logic [WIDTH-1:0] filt,
  input  logic             adj_en,
  input  logic             thresh_sel,
  input  logic             inc_thresh,
  input  logic             dec_thresh,
  output logic             active,
  output logic             onset,
  output logic             release_pulse,
  output logic [WIDTH-1:0] thr_hi,
  output logic [WIDTH-1:0] thr_lo,
  output ch_state_e        state
);

  localparam int               CNT_W     = clog2_min1(MIN_ON + 1);
  localparam int               WP1       = WIDTH + 1;
  localparam logic [CNT_W-1:0] HOLD_DONE = CNT_W'(MIN_ON);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH:0]   STEP      = WP1'(THRESH_STEP);

  ch_state_e        state_next;
  logic [CNT_W-1:0] hold_cnt, hold_next, hold_inc;
  logic             onset_next, release_next;
  logic [WIDTH:0]   sel_old, sel_up;
  logic [WIDTH-1:0] sel_new, hi_next, lo_next;

  assign active = (state != CH_IDLE);

  // Next state of the detector; only a stage-2 evaluation of this channel moves it.
  always_comb begin
    state_next   = state;
    hold_next    = hold_cnt;
    hold_inc     = hold_cnt;
    onset_next   = 1'b0;
    release_next = 1'b0;
    if (hold_cnt < HOLD_DONE) hold_inc = hold_cnt + CNT_W'(1);
    if (eval) begin
      case (state)
        CH_IDLE: begin
          if (filt > thr_hi) begin
            state_next = CH_HOLD;
            hold_next  = '0;
            onset_next = 1'b1;
          end
        end
        default: begin
          // The incremented count is used, so release is possible on the
          // MIN_ON-th evaluation after onset.
          hold_next = hold_inc;
          if (hold_inc >= HOLD_DONE) begin
            if (filt < thr_lo) begin
              state_next   = CH_IDLE;
              release_next = 1'b1;
            end else begin
              state_next = CH_ARMED;
            end
          end else begin
            state_next = CH_HOLD;
          end
        end
      endcase
    end
  end

  // Saturating threshold step; an update that would leave lo >= hi is dropped.
  always_comb begin
    hi_next = thr_hi;
    lo_next = thr_lo;
    sel_old = thresh_sel ? {1'b0, thr_hi} : {1'b0, thr_lo};
    sel_up  = sel_old + STEP;
    if (inc_thresh)          sel_new = sel_up[WIDTH] ? MAX_VAL : sel_up[WIDTH-1:0];
    else if (sel_old >= STEP) sel_new = WIDTH'(sel_old - STEP);
    else                     sel_new = '0;
    if (adj_en && (inc_thresh ^ dec_thresh)) begin
      if (thresh_sel) begin
        if (thr_lo < sel_new) hi_next = sel_new;
      end else begin
        if (sel_new < thr_hi) lo_next = sel_new;
      end
    end
  end

  // Detector and threshold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= CH_IDLE;
      hold_cnt      <= '0;
      onset         <= 1'b0;
      release_pulse <= 1'b0;
      thr_hi        <= WIDTH'(THRESH_HIGH);
      thr_lo        <= WIDTH'(THRESH_LOW);
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_next;
      onset         <= onset_next;
      release_pulse <= release_next;
      thr_hi        <= hi_next;
      thr_lo        <= lo_next;
    end
  end

endmodule

// File: rtl/corr_multi_detector.sv
// Multi-channel correlation detector: shared per-channel IIR low-pass filter
// (one sample per cycle) feeding one hysteresis detector per channel, plus a
// registered readback port. "release" is a reserved word, so the release
// pulse vector is named release_pulse.
module corr_multi_detector
  import corr_multi_detector_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 10,
  parameter int FILTER_SHIFT = 5,
  parameter int THRESH_HIGH  = 450,
  parameter int THRESH_LOW   = 250,
  parameter int THRESH_STEP  = 4,
  parameter int MIN_ON       = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  corr_multi_detector_if.slave            s_if,
  input  logic [clog2_min1(NUM_CH)-1:0]   adj_ch,
  input  logic                            thresh_sel,
  input  logic                            inc_thresh,
  input  logic                            dec_thresh,
  input  logic [clog2_min1(NUM_CH)-1:0]   rd_ch,
  output logic [NUM_CH-1:0]               active,
  output logic [NUM_CH-1:0]               onset,
  output logic [NUM_CH-1:0]               release_pulse,
  output logic [WIDTH-1:0]                rd_filtered,
  output logic [WIDTH-1:0]                rd_thresh_high,
  output logic [WIDTH-1:0]                rd_thresh_low,
  output ch_state_e                       dbg_state [NUM_CH]
);

  localparam int               CH_W    = clog2_min1(NUM_CH);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(sat_max(WIDTH));

  logic [WIDTH-1:0] filt     [NUM_CH];
  logic [WIDTH-1:0] thr_hi_w [NUM_CH];
  logic [WIDTH-1:0] thr_lo_w [NUM_CH];
  logic             in_range, rd_ok, s1_valid;
  logic [CH_W-1:0]  s1_ch;
  logic [WIDTH-1:0] cur_filt, filt_next;
  logic [WIDTH:0]   filt_sum;

  assign in_range = 32'(s_if.correlation_ch) < 32'(NUM_CH);
  assign rd_ok    = 32'(rd_ch) < 32'(NUM_CH);

  // Stage-1 filter step for the tagged channel, one bit wider then clamped.
  always_comb begin
    cur_filt = '0;
    if (in_range) cur_filt = filt[s_if.correlation_ch];
    filt_sum  = {1'b0, cur_filt} + {1'b0, s_if.correlation >> FILTER_SHIFT}
              - {1'b0, cur_filt >> FILTER_SHIFT};
    filt_next = filt_sum[WIDTH] ? MAX_VAL : filt_sum[WIDTH-1:0];
  end

  // Filter state plus the stage-1 -> stage-2 channel tag; out-of-range tags are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) filt[i] <= '0;
      s1_valid <= 1'b0;
      s1_ch    <= '0;
    end else begin
      s1_valid <= s_if.correlation_valid && in_range;
      s1_ch    <= s_if.correlation_ch;
      if (s_if.correlation_valid && in_range) filt[s_if.correlation_ch] <= filt_next;
    end
  end

  // Registered readback of the selected channel; unknown channels read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_filtered    <= '0;
      rd_thresh_high <= '0;
      rd_thresh_low  <= '0;
    end else if (rd_ok) begin
      rd_filtered    <= filt[rd_ch];
      rd_thresh_high <= thr_hi_w[rd_ch];
      rd_thresh_low  <= thr_lo_w[rd_ch];
    end else begin
      rd_filtered    <= '0;
      rd_thresh_high <= '0;
      rd_thresh_low  <= '0;
    end
  end

  // Stage 2: the channel tagged last cycle evaluates its freshly updated filter value.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    corr_hyst_channel #(
      .WIDTH       (WIDTH),
      .THRESH_HIGH (THRESH_HIGH),
      .THRESH_LOW  (THRESH_LOW),
      .THRESH_STEP (THRESH_STEP),
      .MIN_ON      (MIN_ON)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .eval          (s1_valid && (s1_ch == CH_W'(i))),
      .filt          (filt[i]),
      .adj_en        (adj_ch == CH_W'(i)),
      .thresh_sel    (thresh_sel),
      .inc_thresh    (inc_thresh),
      .dec_thresh    (dec_thresh),
      .active        (active[i]),
      .onset         (onset[i]),
      .release_pulse (release_pulse[i]),
      .thr_hi        (thr_hi_w[i]),
      .thr_lo        (thr_lo_w[i]),
      .state         (dbg_state[i])
    );
  end

endmodule
